// File: rtl/clk_run_ctrl_pkg.sv
// clk_run_pkg: state encoding and default sizing shared by the run-control block.
package clk_run_pkg;
    localparam int CNT_W       = 28;
    localparam int CYC_W       = 32;
    localparam int DEFAULT_DIV = 100000000;
    typedef enum logic [1:0] {ST_HALT = 2'd0, ST_RUN = 2'd1, ST_STEP = 2'd2} state_t;
endpackage

// File: rtl/clk_run_ctrl_div_counter.sv
// clk_div_counter: divide counter with a pending divisor that only takes effect on a
// period boundary (or immediately while idle), so a running period is never truncated.
module clk_div_counter #(
    parameter int CNT_W       = clk_run_pkg::CNT_W,
    parameter int DEFAULT_DIV = clk_run_pkg::DEFAULT_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_idle,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_cnt, r_val, r_pend;
    logic             r_pend_vld, w_apply;
    always_comb begin
        o_tc    = i_en && (r_cnt >= r_val);
        w_apply = r_pend_vld && (o_tc || i_idle);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_val      <= CNT_W'(DEFAULT_DIV);
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            r_cnt <= (i_clr || o_tc) ? '0 : (i_en ? r_cnt + 1'b1 : r_cnt);
            if (w_apply)
                r_val <= r_pend;
            // a load coinciding with an apply keeps the flag set so the new value waits
            if (i_load) begin
                r_pend     <= i_div;
                r_pend_vld <= 1'b1;
            end else if (w_apply) begin
                r_pend_vld <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/clk_run_ctrl.sv
// clk_run_ctrl: HALT/RUN/STEP tick scheduler producing a datapath clock enable,
// a divided square wave and a retired-tick counter.
module clk_run_ctrl #(
    parameter int CNT_W       = clk_run_pkg::CNT_W,
    parameter int DEFAULT_DIV = clk_run_pkg::DEFAULT_DIV,
    parameter int CYC_W       = clk_run_pkg::CYC_W
) (
    input  logic             Clk_in,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Step,
    input  logic             Div_load,
    input  logic [CNT_W-1:0] Div_in,
    output logic             Tick,
    output logic             Clk_out,
    output logic             Step_done,
    output logic [1:0]       State,
    output logic [CYC_W-1:0] Cycle_cnt
);
    import clk_run_pkg::*;
    state_t           r_state;
    logic             w_en, w_tc, r_tick, r_clk_out, r_step_done;
    logic [CYC_W-1:0] r_cyc;
    // dropping Run in RUN stops counting this edge, so a coincident terminal count is suppressed
    always_comb begin
        w_en      = (r_state == ST_RUN && Run) || r_state == ST_STEP;
        Tick      = r_tick;
        Clk_out   = r_clk_out;
        Step_done = r_step_done;
        State     = r_state;
        Cycle_cnt = r_cyc;
    end
    clk_div_counter #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_div (
        .i_clk (Clk_in),
        .i_rst (Reset),
        .i_en  (w_en),
        .i_clr (!w_en),
        .i_idle(r_state == ST_HALT),
        .i_load(Div_load),
        .i_div (Div_in),
        .o_tc  (w_tc)
    );
    always_ff @(posedge Clk_in) begin
        if (Reset) begin
            r_state     <= ST_HALT;
            r_tick      <= 1'b0;
            r_clk_out   <= 1'b0;
            r_step_done <= 1'b0;
            r_cyc       <= '0;
        end else begin
            r_tick      <= w_tc;
            r_step_done <= w_tc && r_state == ST_STEP && !Run;
            if (w_tc) begin
                r_clk_out <= !r_clk_out;
                r_cyc     <= r_cyc + 1'b1;
            end
            case (r_state)
                ST_HALT: r_state <= Run ? ST_RUN : (Step ? ST_STEP : ST_HALT);
                ST_RUN:  r_state <= Run ? ST_RUN : ST_HALT;
                ST_STEP: r_state <= Run ? ST_RUN : (w_tc ? ST_HALT : ST_STEP);
                default: r_state <= ST_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_clk_run_ctrl.sv
// tb_clk_run_ctrl: scoreboard bench; an event-time reference model predicts every cycle's
// outputs, a separate monitor compares them against the DUT.
module tb_clk_run_ctrl;
    localparam int DEF  = 3;
    localparam int HALT = 0, RUN = 1, STEP = 2;

    logic       clk = 1'b0;
    logic       rst, run, step, load;
    logic [7:0] din;
    logic       tick, clk_out, sd;
    logic [1:0] st;
    logic [3:0] cyc;

    clk_run_ctrl #(.CNT_W(8), .DEFAULT_DIV(DEF), .CYC_W(4)) dut (
        .Clk_in   (clk),
        .Reset    (rst),
        .Run      (run),
        .Step     (step),
        .Div_load (load),
        .Div_in   (din),
        .Tick     (tick),
        .Clk_out  (clk_out),
        .Step_done(sd),
        .State    (st),
        .Cycle_cnt(cyc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       tick;
        logic       co;
        logic       sd;
        logic [3:0] cnt;
    } rec_t;

    rec_t q[$];
    int   n_tests = 0, n_fail = 0;
    bit   done = 0;

    // model: mode plus the absolute cycle number of the next scheduled tick
    int m_mode = HALT, m_next = 0, m_div = DEF, m_pend = 0, m_cnt = 0, n = 0;
    bit m_pv = 0, m_co = 0;

    task automatic cyc_in(input bit r, input bit ru, input bit s, input bit l, input int d);
        bit tk, sdn;
        tk = 0;
        sdn = 0;
        rst = r; run = ru; step = s; load = l; din = 8'(d);
        n++;
        if (r) begin
            m_mode = HALT; m_div = DEF; m_pv = 0; m_co = 0; m_cnt = 0;
        end else begin
            case (m_mode)
                HALT: begin
                    if (m_pv) begin m_div = m_pend; m_pv = 0; end
                    if (ru || s) begin
                        m_mode = ru ? RUN : STEP;
                        m_next = n + m_div + 1;
                    end
                end
                RUN: begin
                    if (!ru) m_mode = HALT;
                    else if (n == m_next) tk = 1;
                end
                default: begin
                    if (n == m_next) tk = 1;
                    else if (ru) m_mode = RUN;
                end
            endcase
            if (tk) begin
                if (m_pv) begin m_div = m_pend; m_pv = 0; end
                m_next = n + m_div + 1;
                m_co = !m_co;
                m_cnt = (m_cnt + 1) % 16;
                if (m_mode == STEP) begin
                    if (ru) m_mode = RUN;
                    else begin m_mode = HALT; sdn = 1; end
                end
            end
            if (l) begin m_pend = d; m_pv = 1; end
        end
        q.push_back('{2'(m_mode), tk, m_co, sdn, 4'(m_cnt)});
        @(negedge clk);
    endtask

    initial begin
        rec_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL no_expectation at %0t", $time);
            end else begin
                e = q.pop_front();
                a = {st, tick, clk_out, sd, cyc};
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs at %0t: got st=%0d tick=%b clk_out=%b step_done=%b cnt=%0d, expected st=%0d tick=%b clk_out=%b step_done=%b cnt=%0d",
                             $time, a.st, a.tick, a.co, a.sd, a.cnt, e.st, e.tick, e.co, e.sd, e.cnt);
                end
            end
        end
    end

    initial begin
        bit r_lvl;
        r_lvl = 0;
        repeat (2) cyc_in(1, 0, 0, 0, 0);
        repeat (16) cyc_in(0, 1, 0, 0, 0);
        repeat (3) cyc_in(0, 0, 0, 0, 0);
        cyc_in(0, 0, 0, 1, 2);
        repeat (2) cyc_in(0, 0, 0, 0, 0);
        cyc_in(0, 0, 1, 0, 0);
        cyc_in(0, 0, 1, 0, 0);
        repeat (6) cyc_in(0, 0, 0, 0, 0);
        cyc_in(0, 0, 0, 1, 3);
        cyc_in(0, 0, 0, 0, 0);
        repeat (6) cyc_in(0, 1, 0, 0, 0);
        cyc_in(0, 1, 0, 1, 7);
        repeat (30) cyc_in(0, 1, 0, 0, 0);
        repeat (2) cyc_in(0, 0, 0, 0, 0);
        repeat (10) cyc_in(0, 1, 1, 0, 0);
        repeat (2) cyc_in(0, 0, 0, 0, 0);
        cyc_in(0, 0, 1, 0, 0);
        cyc_in(0, 0, 0, 0, 0);
        repeat (10) cyc_in(0, 1, 0, 0, 0);
        cyc_in(1, 1, 0, 0, 0);
        repeat (10) cyc_in(0, 1, 0, 0, 0);
        repeat (2) cyc_in(0, 0, 0, 0, 0);
        cyc_in(0, 0, 0, 1, 0);
        cyc_in(0, 0, 0, 0, 0);
        repeat (40) cyc_in(0, 1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) r_lvl = !r_lvl;
            cyc_in($urandom_range(0, 299) == 0, r_lvl, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 14) == 0, int'($urandom_range(0, 5)));
        end
        done = 1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expectations: got %0d, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
